// File: rtl/ibex_alu_pext_simd_seq_if.sv
// Operand/control request and packed-result response bundle for the Pext SIMD add/sub unit.
// Signal suffixes are from the unit's point of view; the slave modport is the unit.
interface ibex_alu_pext_simd_seq_if;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        width32_i;
    logic        width8_i;
    logic        signed_i;
    logic [1:0]  sub_i;
    logic        sat_i;
    logic        halve_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        ov_o;
    logic        ov_clr_i;

    modport master (
        output valid_i, operand_a_i, operand_b_i, width32_i, width8_i, signed_i, sub_i, sat_i,
               halve_i, flush_i, ready_i, ov_clr_i,
        input  ready_o, valid_o, result_o, ov_o
    );

    modport slave (
        input  valid_i, operand_a_i, operand_b_i, width32_i, width8_i, signed_i, sub_i, sat_i,
               halve_i, flush_i, ready_i, ov_clr_i,
        output ready_o, valid_o, result_o, ov_o
    );
endinterface

// File: rtl/ibex_alu_pext_simd_seq.sv
// Iterative Zpn SIMD add/sub executor: 8/16/32-bit lanes, LanesPerCycle lanes per busy cycle.
// Halving (R) ops are built only when IBEX_PEXT_HALVE_EN is defined.
module ibex_alu_pext_simd_seq #(
    parameter int unsigned LanesPerCycle = 1
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    ibex_alu_pext_simd_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [2:0] Step = 3'(LanesPerCycle);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] a_q, b_q, res_q, res_d;
    logic [1:0]  wsel_q, wsel_in;
    logic [1:0]  sub_q;
    logic        signed_q, sat_q;
    logic        pov_q, pov_d, ov_q, ov_d;
    logic        capture, commit, halve_en;
    logic [2:0]  n_lanes, idx;
    logic [4:0]  shamt;
    logic [31:0] mask;
    logic        sub_sel;
    logic [32:0] lane_r;

    // Returns {overflow, lane}; lane bits above the lane width are don't-care.
    function automatic logic [32:0] lane_op(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] wsel, input logic sgn,
                                            input logic sub, input logic sat, input logic halve);
        logic signed [33:0] ea, eb, s, smax, smin;
        logic [31:0]        lane;
        logic               ov;
        case (wsel)
            2'd0: begin
                ea   = {{26{sgn & a[7]}}, a[7:0]};
                eb   = {{26{sgn & b[7]}}, b[7:0]};
                smax = sgn ? 34'sh7F : 34'shFF;
                smin = sgn ? -34'sh80 : 34'sh0;
            end
            2'd1: begin
                ea   = {{18{sgn & a[15]}}, a[15:0]};
                eb   = {{18{sgn & b[15]}}, b[15:0]};
                smax = sgn ? 34'sh7FFF : 34'shFFFF;
                smin = sgn ? -34'sh8000 : 34'sh0;
            end
            default: begin
                ea   = {{2{sgn & a[31]}}, a};
                eb   = {{2{sgn & b[31]}}, b};
                smax = sgn ? 34'sh7FFF_FFFF : 34'shFFFF_FFFF;
                smin = sgn ? -34'sh8000_0000 : 34'sh0;
            end
        endcase
        s    = sub ? ea - eb : ea + eb;
        lane = s[31:0];
        ov   = 1'b0;
        if (halve) begin
            lane = s[32:1];
        end else if (sat) begin
            if (s > smax) begin
                lane = smax[31:0];
                ov   = 1'b1;
            end else if (s < smin) begin
                lane = smin[31:0];
                ov   = 1'b1;
            end
        end
        return {ov, lane};
    endfunction

`ifdef IBEX_PEXT_HALVE_EN
    logic halve_q;
    assign halve_en = halve_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      halve_q <= 1'b0;
        else if (capture) halve_q <= bus.halve_i;
    end
`else
    logic unused_halve;
    assign unused_halve = bus.halve_i;
    assign halve_en     = 1'b0;
`endif

    // width32 takes priority over width8
    assign wsel_in = bus.width32_i ? 2'd2 : (bus.width8_i ? 2'd0 : 2'd1);
    assign n_lanes = (wsel_q == 2'd2) ? 3'd1 : ((wsel_q == 2'd0) ? 3'd4 : 3'd2);

    assign bus.ready_o  = (state_q == StIdle);
    assign bus.valid_o  = (state_q == StDone);
    assign bus.result_o = res_q;
    assign bus.ov_o     = ov_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        pov_d   = pov_q;
        capture = 1'b0;
        commit  = 1'b0;
        idx     = '0;
        shamt   = '0;
        mask    = '0;
        sub_sel = 1'b0;
        lane_r  = '0;

        for (int unsigned k = 0; k < LanesPerCycle; k++) begin
            idx = cnt_q + 3'(k);
            case (wsel_q)
                2'd0: begin
                    shamt   = {idx[1:0], 3'b000};
                    mask    = 32'h0000_00FF;
                    sub_sel = sub_q[idx[1]];
                end
                2'd1: begin
                    shamt   = {idx[0], 4'b0000};
                    mask    = 32'h0000_FFFF;
                    sub_sel = sub_q[idx[0]];
                end
                default: begin
                    shamt   = '0;
                    mask    = 32'hFFFF_FFFF;
                    sub_sel = sub_q[1];
                end
            endcase
            lane_r = lane_op(a_q >> shamt, b_q >> shamt, wsel_q, signed_q, sub_sel, sat_q,
                             halve_en);
            if (state_q == StBusy && idx < n_lanes) begin
                res_d = (res_d & ~(mask << shamt)) | ((lane_r[31:0] & mask) << shamt);
                pov_d = pov_d | lane_r[32];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.valid_i && !bus.flush_i) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    pov_d   = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + Step;
                if (cnt_q + Step >= n_lanes) state_d = StDone;
            end
            StDone: begin
                if (bus.ready_i) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.flush_i) begin
            state_d = StIdle;
            pov_d   = 1'b0;
            commit  = 1'b0;
        end

        // A same-cycle commit of pending overflow beats the clear
        ov_d = ov_q;
        if (bus.ov_clr_i)       ov_d = 1'b0;
        if (commit && pov_q)    ov_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            res_q    <= '0;
            pov_q    <= 1'b0;
            ov_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            wsel_q   <= '0;
            sub_q    <= '0;
            signed_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            pov_q   <= pov_d;
            ov_q    <= ov_d;
            if (capture) begin
                a_q      <= bus.operand_a_i;
                b_q      <= bus.operand_b_i;
                wsel_q   <= wsel_in;
                sub_q    <= bus.sub_i;
                signed_q <= bus.signed_i;
                sat_q    <= bus.sat_i;
            end
        end
    end

endmodule

// File: tb/tb_ibex_alu_pext_simd_seq.sv
// Directed bench: one DUT per LanesPerCycle value (1 and 2), driven in lockstep and
// compared against hand-computed vectors and multi-cycle corner-case sequences.
module tb_ibex_alu_pext_simd_seq;

`ifdef IBEX_PEXT_HALVE_EN
    localparam bit HalveEn = 1'b1;
`else
    localparam bit HalveEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0, ready_i = 1'b0, flush_i = 1'b0, ov_clr_i = 1'b0;
    logic        w32 = 1'b0, w8 = 1'b0, sgn = 1'b0, sat = 1'b0, halve = 1'b0;
    logic [1:0]  sub = 2'b00;
    logic [31:0] op_a = '0, op_b = '0;

    always #5 clk = ~clk;

    ibex_alu_pext_simd_seq_if u_if0 ();
    ibex_alu_pext_simd_seq_if u_if1 ();

    assign u_if0.valid_i = valid_i;   assign u_if1.valid_i = valid_i;
    assign u_if0.operand_a_i = op_a;  assign u_if1.operand_a_i = op_a;
    assign u_if0.operand_b_i = op_b;  assign u_if1.operand_b_i = op_b;
    assign u_if0.width32_i = w32;     assign u_if1.width32_i = w32;
    assign u_if0.width8_i = w8;       assign u_if1.width8_i = w8;
    assign u_if0.signed_i = sgn;      assign u_if1.signed_i = sgn;
    assign u_if0.sub_i = sub;         assign u_if1.sub_i = sub;
    assign u_if0.sat_i = sat;         assign u_if1.sat_i = sat;
    assign u_if0.halve_i = halve;     assign u_if1.halve_i = halve;
    assign u_if0.flush_i = flush_i;   assign u_if1.flush_i = flush_i;
    assign u_if0.ready_i = ready_i;   assign u_if1.ready_i = ready_i;
    assign u_if0.ov_clr_i = ov_clr_i; assign u_if1.ov_clr_i = ov_clr_i;

    ibex_alu_pext_simd_seq #(.LanesPerCycle(1)) u_dut0 (.clk_i(clk), .rst_ni(rst_ni), .bus(u_if0));
    ibex_alu_pext_simd_seq #(.LanesPerCycle(2)) u_dut1 (.clk_i(clk), .rst_ni(rst_ni), .bus(u_if1));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        w32;
        logic        w8;
        logic        sgn;
        logic [1:0]  sub;
        logic        sat;
        logic        halve;
        logic [31:0] res;
        logic        ov;
    } vec_t;

    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;
    logic ov_model = 1'b0;
    int   lat0, lat1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic start_op(input vec_t v);
        op_a = v.a; op_b = v.b; w32 = v.w32; w8 = v.w8; sgn = v.sgn;
        sub = v.sub; sat = v.sat; halve = v.halve;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the accept edge; 0 means never seen within the bound.
    task automatic wait_valid();
        lat0 = 0;
        lat1 = 0;
        for (int c = 1; c <= 20; c++) begin
            if (lat0 == 0 && u_if0.valid_o) lat0 = c;
            if (lat1 == 0 && u_if1.valid_o) lat1 = c;
            if (lat0 != 0 && lat1 != 0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int n;
        n = v.w32 ? 1 : (v.w8 ? 4 : 2);
        start_op(v);
        wait_valid();
        chk({name, " lat L1"}, 32'(lat0), 32'(n + 1));
        chk({name, " lat L2"}, 32'(lat1), 32'((n + 1) / 2 + 1));
        chk({name, " res L1"}, u_if0.result_o, v.res);
        chk({name, " res L2"}, u_if1.result_o, v.res);
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        ov_model = ov_model | v.ov;
        chk1({name, " ov L1"}, u_if0.ov_o, ov_model);
        chk1({name, " ov L2"}, u_if1.ov_o, ov_model);
        chk1({name, " idle"}, u_if0.ready_o & ~u_if0.valid_o, 1'b1);
    endtask

    initial begin
        //           a             b             w32   w8    sgn   sub    sat   halve result ov
        vecs[0]  = '{32'h7F8001FF, 32'h01FF0101, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0,
                     32'h7F800200, 1'b1};
        vecs[1]  = '{32'hFFFF0001, 32'h00010003, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1,
                     HalveEn ? 32'h8000FFFF : 32'h0000FFFE, 1'b0};
        vecs[2]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0,
                     32'h80000000, 1'b1};
        vecs[3]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0,
                     32'h00000000, 1'b0};
        vecs[4]  = '{32'h1005FF00, 32'h20030101, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0,
                     32'h0002FE00, 1'b1};
        vecs[5]  = '{32'hFFF01234, 32'h00200001, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0,
                     32'hFFFF1235, 1'b1};
        vecs[6]  = '{32'h7FFF8000, 32'h00010001, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0,
                     32'h7FFF8000, 1'b1};
        vecs[7]  = '{32'h807F1005, 32'h01012003, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0,
                     32'h7F7E3008, 1'b0};
        vecs[8]  = '{32'h807FFF01, 32'h807FFF02, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1,
                     HalveEn ? 32'h807FFF01 : 32'h807FFE03, !HalveEn};
        vecs[9]  = '{32'h00000000, 32'h00000002, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1,
                     HalveEn ? 32'hFFFFFFFF : 32'hFFFFFFFE, 1'b0};
        vecs[10] = '{32'h000000FF, 32'h00000001, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0,
                     32'h00000100, 1'b0};
        vecs[11] = '{32'h80000003, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1,
                     HalveEn ? 32'h80000002 : 32'h00010004, 1'b0};

        #12;
        chk1("reset ready", u_if0.ready_o, 1'b1);
        chk1("reset valid", u_if0.valid_o, 1'b0);
        chk("reset result", u_if0.result_o, 32'h0);
        chk1("reset ov", u_if0.ov_o, 1'b0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Clear alone
        ov_clr_i = 1'b1;
        @(posedge clk); #1;
        ov_clr_i = 1'b0;
        ov_model = 1'b0;
        chk1("clr alone ov", u_if0.ov_o, 1'b0);

        // Backpressure in DONE: result held, ov only moves on the handshake
        start_op(vecs[6]);
        wait_valid();
        chk("bp lat L1", 32'(lat0), 32'd3);
        chk("bp lat L2", 32'(lat1), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk1("bp valid", u_if0.valid_o & u_if1.valid_o, 1'b1);
            chk("bp res L1", u_if0.result_o, vecs[6].res);
            chk("bp res L2", u_if1.result_o, vecs[6].res);
            chk1("bp ready", u_if0.ready_o | u_if1.ready_o, 1'b0);
            chk1("bp ov held", u_if0.ov_o | u_if1.ov_o, 1'b0);
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        chk1("bp ov L1", u_if0.ov_o, 1'b1);
        chk1("bp ov L2", u_if1.ov_o, 1'b1);

        ov_clr_i = 1'b1;
        @(posedge clk); #1;
        ov_clr_i = 1'b0;

        // Flush in the second busy cycle of an overflowing op
        start_op(vecs[0]);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk1("flush ready L1", u_if0.ready_o, 1'b1);
        chk1("flush ready L2", u_if1.ready_o, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk1("flush no valid", u_if0.valid_o | u_if1.valid_o, 1'b0);
            @(posedge clk); #1;
        end
        chk1("flush ov", u_if0.ov_o | u_if1.ov_o, 1'b0);

        // Flush in IDLE blocks an accept
        op_a = 32'h1; op_b = 32'h1; w32 = 1'b1; w8 = 1'b0;
        valid_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk1("idle flush ready", u_if0.ready_o & u_if1.ready_o, 1'b1);
        @(posedge clk); #1;
        chk1("idle flush no valid", u_if0.valid_o | u_if1.valid_o, 1'b0);

        // Clear and pending-ov commit in the same cycle: set wins
        ov_model = 1'b0;
        run_vec(vecs[2], "pre-clr");
        start_op(vecs[0]);
        wait_valid();
        ready_i = 1'b1;
        ov_clr_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        ov_clr_i = 1'b0;
        chk1("clr+commit ov L1", u_if0.ov_o, 1'b1);
        chk1("clr+commit ov L2", u_if1.ov_o, 1'b1);
        ov_clr_i = 1'b1;
        @(posedge clk); #1;
        ov_clr_i = 1'b0;
        chk1("clr after ov", u_if0.ov_o, 1'b0);
        ov_model = 1'b0;

        // Asynchronous reset mid-operation
        start_op(vecs[7]);
        @(posedge clk); #2;
        rst_ni = 1'b0;
        #1;
        chk1("areset ready", u_if0.ready_o, 1'b1);
        chk1("areset valid", u_if0.valid_o | u_if1.valid_o, 1'b0);
        chk("areset result L1", u_if0.result_o, 32'h0);
        chk("areset result L2", u_if1.result_o, 32'h0);
        #2;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[5], "post-reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_alu_pext_simd_seq.md
Name: ibex_alu_pext_simd_seq

Overview:
Iterative SIMD add/sub executor that consumes the Zpn control word produced by the Pext decode stage: lane width, signedness, per-half subtract select, and saturate/halve mode. It processes packed 8/16/32-bit lanes one or two lanes per cycle. Operands arrive through a valid/ready handshake, and the packed result leaves through a second valid/ready handshake. It keeps the sticky P-extension overflow (OV) flag for saturating ops.

Parameters:
LanesPerCycle, 1, lanes computed per busy cycle; legal values 1 or 2.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  operand/control valid
ready_o  output  1  unit can accept
operand_a_i  input  32  packed rs1
operand_b_i  input  32  packed rs2
width32_i  input  1  one 32-bit lane
width8_i  input  1  four 8-bit lanes; if neither width bit is set, two 16-bit lanes
signed_i  input  1  signed lane arithmetic
sub_i  input  2  bit0: subtract in low half (bytes 0-1 / H0); bit1: subtract in high half (bytes 2-3 / H1 / word)
sat_i  input  1  saturating (K) op
halve_i  input  1  halving (R) op
flush_i  input  1  abort current op
valid_o  output  1  result valid
ready_i  input  1  consumer accepts result
result_o  output  32  packed result
ov_o  output  1  sticky overflow flag
ov_clr_i  input  1  clear ov_o

Behaviour:
- Reset values: state IDLE, ready_o=1, valid_o=0, result_o=0, ov_o=0. Lane counter and captured operands reset to 0.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o: capture operands and controls, clear the lane counter, go to BUSY.
  - If width32_i and width8_i are both set, width32 wins.
- BUSY:
  - ready_o=0.
  - Each cycle computes lanes cnt..cnt+LanesPerCycle-1, writes them into the result register and ORs their overflow into a pending-ov register.
  - Lane count N=4 (8-bit), 2 (16-bit), 1 (32-bit).
  - After the last lane, go to DONE.
  - BUSY lasts ceil(N/LanesPerCycle) cycles. valid_o rises ceil(N/LanesPerCycle)+1 cycles after the accept edge.
- DONE:
  - valid_o=1. result_o is held stable until valid_o&&ready_i.
  - On handshake: ov_o |= pending-ov, go to IDLE.
  - The next op is accepted no earlier than the following cycle; there is no IDLE bypass.
- Lane arithmetic, width W:
  - Operands are extended to W+1 bits: sign-extended if signed_i, else zero-extended.
  - s = a+b, or a-b when the sub_i bit for that lane's half is set. For 32-bit lanes sub_i[1] is used.
  - halve_i: lane = s[W:1]. Never overflows; ov not contributed.
  - sat_i (halve_i clear):
    - signed: clamp to [-2^(W-1), 2^(W-1)-1].
    - unsigned: clamp to [0, 2^W-1].
    - Lane ov=1 when clamped.
  - Neither set: lane = s[W-1:0], wrap, ov=0.
  - halve_i and sat_i both set: halve wins.
- flush_i:
  - From any state, go to IDLE next cycle, valid_o=0, pending-ov discarded, ov_o unchanged.
  - flush_i in IDLE while valid_i is high: no accept.
  - flush_i wins over a same-cycle handshake.
- ov_clr_i: ov_o<=0 next cycle. If the same cycle commits pending-ov=1, set wins (ov_o=1).
- Asynchronous reset mid-operation aborts immediately to reset values.

Optional Feature:
IBEX_PEXT_HALVE_EN
- Defined: halving (R-op) path present as above.
- Undefined:
  - halve_i is ignored and treated as 0; the halving datapath is not built.
  - An op with halve_i=1, sat_i=0 produces the wrapped result.
  - An op with halve_i=1, sat_i=1 saturates.

Test Plan:
1. 8-bit signed sat add, a=0x7F8001FF, b=0x01FF0101, LanesPerCycle=1 -> result_o=0x7F800200, valid_o 5 cycles after accept, ov_o=1 after handshake.
2. 16-bit unsigned halving, sub_i=01, a=0xFFFF0001, b=0x00010003 -> result_o=0x8000FFFF, ov_o stays 0, valid_o 3 cycles after accept; with IBEX_PEXT_HALVE_EN undefined -> 0x0000FFFE.
3. 32-bit signed sat sub, a=0x80000000, b=0x00000001 -> 0x80000000, ov_o=1; unsigned wrap add 0xFFFFFFFF+1 -> 0x00000000, ov_o unchanged.
4. Backpressure: ready_i=0 for 5 cycles in DONE -> valid_o=1 and result_o stable, ready_o=0, ov_o updates only on the handshake cycle; LanesPerCycle=2, 8-bit op -> valid_o 3 cycles after accept.
5. flush_i asserted in 2nd BUSY cycle of an overflowing 8-bit sat op -> IDLE next cycle, ready_o=1, valid_o never rises, ov_o=0.
6. ov_o=1, ov_clr_i on the same cycle as a handshake with pending-ov=1 -> ov_o stays 1; ov_clr_i alone next cycle -> ov_o=0.
